// File: rtl/bcd2bin_seq.sv
// Sequential two-digit BCD to binary converter using reverse double-dabble (7 iterations).
// Optional invalid-digit check enabled by defining BCD_CHECK_EN.
module bcd2bin_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic [6:0] bin,
    output logic       err
);

    localparam int unsigned BCD_W = 8;
    localparam int unsigned BIN_W = 7;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(6);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_r, bcd_nxt;
    logic [BIN_W-1:0]   bin_r, bin_r_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIN_W-1:0]   bin_nxt;
    logic               busy_nxt, done_nxt;
    logic [BCD_W+BIN_W-1:0] sh;
    logic [BCD_W-1:0]   iter_bcd;
    logic [BIN_W-1:0]   iter_bin;

    // One reverse double-dabble step: shift right, then subtract 3 from digits >= 8
    always_comb begin
        sh       = {bcd_r, bin_r} >> 1;
        iter_bin = sh[BIN_W-1:0];
        iter_bcd[7:4] = (sh[14:11] >= 4'd8) ? sh[14:11] - 4'd3 : sh[14:11];
        iter_bcd[3:0] = (sh[10:7]  >= 4'd8) ? sh[10:7]  - 4'd3 : sh[10:7];
    end

`ifdef BCD_CHECK_EN
    logic bad_r, bad_nxt;
    logic err_r, err_nxt;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Next-state and datapath/output next values
    always_comb begin
        state_nxt = state;
        bcd_nxt   = bcd_r;
        bin_r_nxt = bin_r;
        cnt_nxt   = cnt;
        bin_nxt   = bin;
        done_nxt  = 1'b0;
`ifdef BCD_CHECK_EN
        bad_nxt   = bad_r;
        err_nxt   = err_r;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    bcd_nxt   = {tens, ones};
                    bin_r_nxt = '0;
                    cnt_nxt   = '0;
`ifdef BCD_CHECK_EN
                    bad_nxt   = (tens > 4'd9) || (ones > 4'd9);
                    state_nxt = bad_nxt ? DONE : SHIFT;
`else
                    state_nxt = SHIFT;
`endif
                end
            end
            SHIFT: begin
                bcd_nxt   = iter_bcd;
                bin_r_nxt = iter_bin;
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
`ifdef BCD_CHECK_EN
                bin_nxt   = bad_r ? '0 : bin_r;
                err_nxt   = bad_r;
`else
                bin_nxt   = bin_r;
`endif
            end
            default: state_nxt = IDLE;
        endcase
        // busy covers the capture cycle through the cycle carrying the done pulse
        busy_nxt = (state_nxt != IDLE) || (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bcd_r <= '0;
            bin_r <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
`ifdef BCD_CHECK_EN
            bad_r <= 1'b0;
            err_r <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            bcd_r <= bcd_nxt;
            bin_r <= bin_r_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            bin   <= bin_nxt;
`ifdef BCD_CHECK_EN
            bad_r <= bad_nxt;
            err_r <= err_nxt;
`endif
        end
    end

endmodule
